atomrvcore_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the execute stage.
- Decides operand-forwarding selects for the next instruction entering EX.
- Detects load-use hazards and inserts one bubble.
- Sequences pipeline flushes after taken branches and jumps.
- Holds the whole front-end when memory back-pressures.
- Sits between decode (ID) and the EX/ALU stage; drives the ALU operand muxes and the IF/ID/EX pipeline-register enables.

---
 rtl/atomrvcore_pkg.sv | 26 ++
 rtl/atomrvcore_fwd_cmp.sv | 15 +
 rtl/atomrvcore_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_atomrvcore_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atomrvcore_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding selects,
// controller states and the flush-counter width.
package atomrvcore_pkg;

    localparam int REG_ADRESS_WIDTH = 5;
    localparam int FLUSH_CNT_W      = 3;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } hz_state_e;

    // A load in EX cannot feed EX/MEM forwarding; the MEM-distance match is the fallback.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit,
                                          input logic load_use);
        return (ex_hit && !load_use) ? FWD_EXMEM : (mem_hit ? FWD_MEMWB : FWD_RF);
    endfunction

endpackage

// File: rtl/atomrvcore_fwd_cmp.sv
// Single-operand hazard comparator: source read matches a live, non-x0 destination.
// Purely combinational, no latency, no backpressure.
module atomrvcore_fwd_cmp #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs_i,
    input  logic          used_i,
    input  logic [AW-1:0] rd_i,
    input  logic          wen_i,
    output logic          hit_o
);

    assign hit_o = used_i & wen_i & (rs_i == rd_i) & (|rd_i);

endmodule

// File: rtl/atomrvcore_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects (1-cycle registered), load-use bubble,
// redirect flush sequencing, ext_stall_i freezes everything. Optional ATOMRV_HAZARD_PERF_EN.
module atomrvcore_hazard_ctrl #(
    parameter int REG_ADRESS_WIDTH = atomrvcore_pkg::REG_ADRESS_WIDTH,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
    input  logic                        id_rs1_used_i,
    input  logic                        id_rs2_used_i,
    input  logic [REG_ADRESS_WIDTH-1:0] ex_rd_i,
    input  logic                        ex_rwr_en_i,
    input  logic                        ex_dr_en_i,
    input  logic [REG_ADRESS_WIDTH-1:0] mem_rd_i,
    input  logic                        mem_rwr_en_i,
    input  logic                        redirect_i,
    input  logic                        ext_stall_i,
    output logic [1:0]                  fwd1_o,
    output logic [1:0]                  fwd2_o,
    output logic                        pc_stall_o,
    output logic                        if_id_stall_o,
    output logic                        id_ex_bubble_o,
    output logic                        flush_o,
    output logic                        busy_o
`ifdef ATOMRV_HAZARD_PERF_EN
    ,
    output logic [31:0]                 stall_cnt_o,
    output logic [31:0]                 flush_cnt_o
`endif
);
    import atomrvcore_pkg::*;

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_e              state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   redir_pend_q, redir_pend_d;
    fwd_sel_e               fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    logic hit_rs1_ex, hit_rs2_ex, hit_rs1_mem, hit_rs2_mem;
    logic load_use, redir;
    logic stall, bubble, flush;

    atomrvcore_fwd_cmp #(.AW(REG_ADRESS_WIDTH)) u_cmp_rs1_ex (
        .rs_i(id_rs1_i), .used_i(id_rs1_used_i), .rd_i(ex_rd_i), .wen_i(ex_rwr_en_i),
        .hit_o(hit_rs1_ex)
    );
    atomrvcore_fwd_cmp #(.AW(REG_ADRESS_WIDTH)) u_cmp_rs2_ex (
        .rs_i(id_rs2_i), .used_i(id_rs2_used_i), .rd_i(ex_rd_i), .wen_i(ex_rwr_en_i),
        .hit_o(hit_rs2_ex)
    );
    atomrvcore_fwd_cmp #(.AW(REG_ADRESS_WIDTH)) u_cmp_rs1_mem (
        .rs_i(id_rs1_i), .used_i(id_rs1_used_i), .rd_i(mem_rd_i), .wen_i(mem_rwr_en_i),
        .hit_o(hit_rs1_mem)
    );
    atomrvcore_fwd_cmp #(.AW(REG_ADRESS_WIDTH)) u_cmp_rs2_mem (
        .rs_i(id_rs2_i), .used_i(id_rs2_used_i), .rd_i(mem_rd_i), .wen_i(mem_rwr_en_i),
        .hit_o(hit_rs2_mem)
    );

    assign load_use = ex_dr_en_i & (hit_rs1_ex | hit_rs2_ex);
    // A redirect seen under ext_stall_i is replayed from redir_pend_q once the stall drops.
    assign redir    = redirect_i | redir_pend_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        redir_pend_d = redir_pend_q;
        fwd1_d       = fwd1_q;
        fwd2_d       = fwd2_q;
        stall        = 1'b0;
        bubble       = 1'b0;
        flush        = 1'b0;

        if (ext_stall_i) begin
            stall        = 1'b1;
            redir_pend_d = redir;
        end else begin
            redir_pend_d = 1'b0;
            fwd1_d       = fwd_pick(hit_rs1_ex, hit_rs1_mem, load_use);
            fwd2_d       = fwd_pick(hit_rs2_ex, hit_rs2_mem, load_use);
            if (redir) begin
                flush  = 1'b1;
                fwd1_d = FWD_RF;
                fwd2_d = FWD_RF;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end else begin
                unique case (state_q)
                    FLUSH: begin
                        flush  = 1'b1;
                        fwd1_d = FWD_RF;
                        fwd2_d = FWD_RF;
                        if (cnt_q <= FLUSH_CNT_W'(1)) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - FLUSH_CNT_W'(1);
                        end
                    end
                    LDSTALL: state_d = RUN;
                    default: begin
                        if (load_use) begin
                            stall   = 1'b1;
                            bubble  = 1'b1;
                            fwd1_d  = FWD_RF;
                            fwd2_d  = FWD_RF;
                            state_d = LDSTALL;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            redir_pend_q <= 1'b0;
            fwd1_q       <= FWD_RF;
            fwd2_q       <= FWD_RF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            redir_pend_q <= redir_pend_d;
            fwd1_q       <= fwd1_d;
            fwd2_q       <= fwd2_d;
        end
    end

    // Combinational controls are forced low for the whole reset window, not just at the edge.
    assign pc_stall_o     = rst_ni & stall;
    assign if_id_stall_o  = rst_ni & stall;
    assign id_ex_bubble_o = rst_ni & bubble;
    assign flush_o        = rst_ni & flush;
    assign fwd1_o         = fwd1_q;
    assign fwd2_o         = fwd2_q;
    assign busy_o         = (state_q != RUN);

`ifdef ATOMRV_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (id_ex_bubble_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_o)        flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_atomrvcore_hazard_ctrl.sv
// Bench for atomrvcore_hazard_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a cycle-level model of the hazard rules.
module tb_atomrvcore_hazard_ctrl;

    localparam int FC = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
    logic       id_rs1_used_i, id_rs2_used_i, ex_rwr_en_i, ex_dr_en_i, mem_rwr_en_i;
    logic       redirect_i, ext_stall_i;
    logic [1:0] fwd1_o, fwd2_o;
    logic       pc_stall_o, if_id_stall_o, id_ex_bubble_o, flush_o, busy_o;
`ifdef ATOMRV_HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    atomrvcore_hazard_ctrl #(.REG_ADRESS_WIDTH(5), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_i(ex_rd_i), .ex_rwr_en_i(ex_rwr_en_i), .ex_dr_en_i(ex_dr_en_i),
        .mem_rd_i(mem_rd_i), .mem_rwr_en_i(mem_rwr_en_i),
        .redirect_i(redirect_i), .ext_stall_i(ext_stall_i),
        .fwd1_o(fwd1_o), .fwd2_o(fwd2_o),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
        .id_ex_bubble_o(id_ex_bubble_o), .flush_o(flush_o), .busy_o(busy_o)
`ifdef ATOMRV_HAZARD_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int rs1, rs2, u1, u2, exrd, exw, exld, memrd, memw, redir, est;
        int e_stall, e_bub, e_fl, e_f1, e_f2, e_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        id_rs1_i = '0; id_rs2_i = '0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        ex_rd_i = '0; ex_rwr_en_i = 0; ex_dr_en_i = 0;
        mem_rd_i = '0; mem_rwr_en_i = 0; redirect_i = 0; ext_stall_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        set_idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic bit mhit(int rs, bit used, int rd, bit wen);
        return used && wen && (rs == rd) && (rd != 0);
    endfunction

    function automatic int mpick(bit ex_hit, bit mem_hit, bit lu);
        if (ex_hit && !lu) return 1;
        if (mem_hit) return 2;
        return 0;
    endfunction

    // Model state: remaining extra flush cycles, "previous cycle was a bubble", pending redirect.
    int  m_flush_left, m_f1, m_f2;
    bit  m_after_bubble, m_pend;
    longint m_stall_cnt, m_flush_cnt;

    initial begin
        vecs[0]  = '{5,0,1,0, 5,1,0, 0,0,0,0,  0,0,0, 1,0,0};
        vecs[1]  = '{0,7,0,1, 7,1,1, 0,0,0,0,  1,1,0, 0,0,1};
        vecs[2]  = '{3,0,1,0, 3,1,0, 3,1,0,0,  0,0,0, 1,0,0};
        vecs[3]  = '{0,0,1,1, 0,1,0, 0,1,0,0,  0,0,0, 0,0,0};
        vecs[4]  = '{9,9,1,1, 2,1,0, 9,1,0,0,  0,0,0, 2,2,0};
        vecs[5]  = '{5,5,0,0, 5,1,0, 5,1,0,0,  0,0,0, 0,0,0};
        vecs[6]  = '{4,6,1,1, 4,0,0, 4,1,0,0,  0,0,0, 2,0,0};
        vecs[7]  = '{0,7,0,1, 7,1,1, 0,0,1,0,  0,0,1, 0,0,1};
        vecs[8]  = '{5,0,1,0, 5,1,0, 0,0,0,1,  1,0,0, 0,0,0};
        vecs[9]  = '{6,0,1,0, 6,1,1, 6,1,0,0,  1,1,0, 0,0,1};
        vecs[10] = '{8,10,1,1, 10,1,0, 8,1,0,0, 0,0,0, 2,1,0};

        rst_ni = 1'b0;
        set_idle();
        #3;
        chk("reset_fwd1", int'(fwd1_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_stall", int'(pc_stall_o), 0);
        do_reset();

        // Directed single-cycle vectors, each from a clean RUN state.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            id_rs1_i = 5'(vecs[i].rs1); id_rs2_i = 5'(vecs[i].rs2);
            id_rs1_used_i = 1'(vecs[i].u1); id_rs2_used_i = 1'(vecs[i].u2);
            ex_rd_i = 5'(vecs[i].exrd); ex_rwr_en_i = 1'(vecs[i].exw); ex_dr_en_i = 1'(vecs[i].exld);
            mem_rd_i = 5'(vecs[i].memrd); mem_rwr_en_i = 1'(vecs[i].memw);
            redirect_i = 1'(vecs[i].redir); ext_stall_i = 1'(vecs[i].est);
            @(negedge clk_i);
            chk($sformatf("vec%0d_pc_stall", i), int'(pc_stall_o), vecs[i].e_stall);
            chk($sformatf("vec%0d_if_id_stall", i), int'(if_id_stall_o), vecs[i].e_stall);
            chk($sformatf("vec%0d_bubble", i), int'(id_ex_bubble_o), vecs[i].e_bub);
            chk($sformatf("vec%0d_flush", i), int'(flush_o), vecs[i].e_fl);
            tick();
            set_idle();
            @(negedge clk_i);
            chk($sformatf("vec%0d_fwd1", i), int'(fwd1_o), vecs[i].e_f1);
            chk($sformatf("vec%0d_fwd2", i), int'(fwd2_o), vecs[i].e_f2);
            chk($sformatf("vec%0d_busy", i), int'(busy_o), vecs[i].e_busy);
            tick();
        end

        // Load-use: bubble, one LDSTALL cycle, then MEM/WB forwarding for the held instruction.
        do_reset();
        ex_rd_i = 7; ex_rwr_en_i = 1; ex_dr_en_i = 1; id_rs2_i = 7; id_rs2_used_i = 1;
        @(negedge clk_i);
        chk("ld_bubble", int'(id_ex_bubble_o), 1);
        tick();
        ex_rd_i = 0; ex_rwr_en_i = 0; ex_dr_en_i = 0; mem_rd_i = 7; mem_rwr_en_i = 1;
        @(negedge clk_i);
        chk("ld_stallstate_busy", int'(busy_o), 1);
        chk("ld_stallstate_pc_stall", int'(pc_stall_o), 0);
        chk("ld_stallstate_bubble", int'(id_ex_bubble_o), 0);
        tick();
        set_idle();
        @(negedge clk_i);
        chk("ld_fwd2_memwb", int'(fwd2_o), 2);
        chk("ld_done_busy", int'(busy_o), 0);
        tick();

        // Redirect pulse: flush lasts FC cycles, busy FC-1 cycles.
        do_reset();
        begin
            int fl_n = 0, busy_n = 0;
            redirect_i = 1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk_i);
                fl_n += int'(flush_o);
                busy_n += int'(busy_o);
                tick();
                redirect_i = 0;
            end
            chk("redir_flush_cycles", fl_n, FC);
            chk("redir_busy_cycles", busy_n, FC - 1);
        end

        // Redirect during ext_stall is deferred until the stall drops.
        do_reset();
        ext_stall_i = 1; redirect_i = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("estall%0d_flush", c), int'(flush_o), 0);
            chk($sformatf("estall%0d_pc_stall", c), int'(pc_stall_o), 1);
            tick();
            redirect_i = 0;
        end
        ext_stall_i = 0;
        @(negedge clk_i);
        chk("estall_release_flush", int'(flush_o), 1);
        chk("estall_release_pc_stall", int'(pc_stall_o), 0);
        tick();
        @(negedge clk_i);
        chk("estall_flushstate_flush", int'(flush_o), 1);
        chk("estall_flushstate_busy", int'(busy_o), 1);
        tick();
        @(negedge clk_i);
        chk("estall_done_flush", int'(flush_o), 0);
        tick();

        // Asynchronous reset in the last FLUSH cycle.
        do_reset();
        redirect_i = 1;
        tick();
        redirect_i = 0;
        @(negedge clk_i);
        chk("midflush_flush_before", int'(flush_o), 1);
        #1;
        rst_ni = 0;
        ext_stall_i = 1;
        #1;
        chk("midflush_rst_flush", int'(flush_o), 0);
        chk("midflush_rst_busy", int'(busy_o), 0);
        chk("midflush_rst_pc_stall", int'(pc_stall_o), 0);
        chk("midflush_rst_fwd1", int'(fwd1_o), 0);
        @(posedge clk_i);
        #2;
        set_idle();
        rst_ni = 1;
        @(negedge clk_i);
        chk("midflush_post_busy", int'(busy_o), 0);
        chk("midflush_post_flush", int'(flush_o), 0);
        chk("midflush_post_fwd2", int'(fwd2_o), 0);
`ifdef ATOMRV_HAZARD_PERF_EN
        chk("midflush_post_stall_cnt", int'(stall_cnt_o), 0);
        chk("midflush_post_flush_cnt", int'(flush_cnt_o), 0);
`endif
        tick();

        // Randomized traffic against the model.
        do_reset();
        m_flush_left = 0; m_f1 = 0; m_f2 = 0; m_after_bubble = 0; m_pend = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            bit h1e, h2e, h1m, h2m, lu, e_st, e_bub, e_fl, e_busy;
            int n_f1, n_f2;
            id_rs1_i = 5'($urandom_range(0, 3));
            id_rs2_i = 5'($urandom_range(0, 3));
            ex_rd_i  = 5'($urandom_range(0, 3));
            mem_rd_i = 5'($urandom_range(0, 3));
            id_rs1_used_i = 1'($urandom_range(0, 1));
            id_rs2_used_i = 1'($urandom_range(0, 1));
            ex_rwr_en_i   = 1'($urandom_range(0, 1));
            mem_rwr_en_i  = 1'($urandom_range(0, 1));
            ex_dr_en_i    = ($urandom_range(0, 2) == 0);
            redirect_i    = ($urandom_range(0, 7) == 0);
            ext_stall_i   = ($urandom_range(0, 4) == 0);
            @(negedge clk_i);

            h1e = mhit(int'(id_rs1_i), id_rs1_used_i, int'(ex_rd_i), ex_rwr_en_i);
            h2e = mhit(int'(id_rs2_i), id_rs2_used_i, int'(ex_rd_i), ex_rwr_en_i);
            h1m = mhit(int'(id_rs1_i), id_rs1_used_i, int'(mem_rd_i), mem_rwr_en_i);
            h2m = mhit(int'(id_rs2_i), id_rs2_used_i, int'(mem_rd_i), mem_rwr_en_i);
            lu  = ex_dr_en_i && (h1e || h2e);
            e_busy = (m_flush_left > 0) || m_after_bubble;
            e_st = 0; e_bub = 0; e_fl = 0;
            n_f1 = m_f1; n_f2 = m_f2;
            if (ext_stall_i) begin
                e_st = 1;
                m_pend = m_pend || redirect_i;
            end else begin
                n_f1 = mpick(h1e, h1m, lu);
                n_f2 = mpick(h2e, h2m, lu);
                if (redirect_i || m_pend) begin
                    e_fl = 1; n_f1 = 0; n_f2 = 0;
                    m_flush_left = FC - 1;
                    m_after_bubble = 0;
                end else if (m_flush_left > 0) begin
                    e_fl = 1; n_f1 = 0; n_f2 = 0;
                    m_flush_left--;
                end else if (m_after_bubble) begin
                    m_after_bubble = 0;
                end else if (lu) begin
                    e_st = 1; e_bub = 1; n_f1 = 0; n_f2 = 0;
                    m_after_bubble = 1;
                end
                m_pend = 0;
            end

            chk("rnd_pc_stall", int'(pc_stall_o), int'(e_st));
            chk("rnd_if_id_stall", int'(if_id_stall_o), int'(e_st));
            chk("rnd_bubble", int'(id_ex_bubble_o), int'(e_bub));
            chk("rnd_flush", int'(flush_o), int'(e_fl));
            chk("rnd_busy", int'(busy_o), int'(e_busy));
            chk("rnd_fwd1", int'(fwd1_o), m_f1);
            chk("rnd_fwd2", int'(fwd2_o), m_f2);
            m_f1 = n_f1; m_f2 = n_f2;
            m_stall_cnt += longint'(e_bub);
            m_flush_cnt += longint'(e_fl);
            tick();
        end
`ifdef ATOMRV_HAZARD_PERF_EN
        @(negedge clk_i);
        chk("perf_stall_cnt", int'(stall_cnt_o), int'(m_stall_cnt));
        chk("perf_flush_cnt", int'(flush_cnt_o), int'(m_flush_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
